param_cpu_core: RTL and testbench
=================================

PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
REQ-001 The block SHALL take parameter DW, default 8, datapath and register width in bits; legal values are 8 and above.
REQ-002 The block SHALL take parameter AW, default 8, memory address and PC width in bits.
REQ-003 Reset SHALL be named reset and SHALL be synchronous and active-high; the clock SHALL be named clk.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  AW  request address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid in the ack cycle
- mem_ack  in  1  completes the request in the same cycle
- halted  out  1  core stopped
- error  out  1  illegal opcode caused the stop
- dbg_pc  out  AW  current PC

Function
REQ-005 The instruction SHALL be mem_rdata[7:0] of the fetch word: opcode [7:4], src [3:2], dest [1:0]; four registers R0-R3, each DW bits wide.
REQ-006 Opcodes SHALL be: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 NOT, 5 RD, 6 WR, 7 BR, 8 BRZ, 9 LDI, F HALT; every other value is illegal.
REQ-007 Handshake: once mem_req is high, mem_addr, mem_we and mem_wdata SHALL stay stable until the cycle in which mem_ack=1; the transfer completes in that cycle; mem_ack while mem_req=0 SHALL be ignored.
REQ-008 FSM states SHALL be: FETCH, DECODE, OPND, DATA, HALT.
REQ-009 FETCH: request addr=PC with we=0; on ack, load IR, set PC<=PC+1, go to DECODE.
REQ-010 DECODE for ADD/SUB/AND: Rdest<=Rdest op Rsrc, with SUB = Rdest-Rsrc; results wrap modulo 2^DW; flag<=(result==0); go to FETCH.
REQ-011 DECODE for NOT: Rdest<=~Rsrc, update flag, go to FETCH.
REQ-012 DECODE for NOP: go to FETCH with no state change.
REQ-013 Only ALU opcodes (1-4) SHALL change the flag.
REQ-014 DECODE for RD, WR, BR, LDI, and for BRZ with flag=1: go to OPND.
REQ-015 DECODE for BRZ with flag=0: PC<=PC+1, skipping the operand word, and go to FETCH.
REQ-016 OPND: request addr=PC with we=0; on ack, PC<=PC+1.
- RD/WR: AR<=rdata[AW-1:0], go to DATA.
- BR/BRZ: PC<=rdata[AW-1:0] instead of PC+1, go to FETCH.
- LDI: Rdest<=rdata, go to FETCH.
REQ-017 DATA: request addr=AR.
- RD: we=0; on ack, Rdest<=rdata.
- WR: we=1, wdata=Rsrc.
- On ack, go to FETCH.
REQ-018 PC SHALL wrap from 2^AW-1 to 0.
REQ-019 HALT opcode SHALL enter HALT with error=0; an illegal opcode SHALL enter HALT with error=1.
REQ-020 In HALT: halted=1, mem_req=0, and the core stays there until reset.
REQ-021 Best-case latency SHALL be: NOP/ALU 3 cycles; BR/LDI 4 cycles; RD/WR 5 cycles; each wait cycle without ack adds one cycle.

Reset
REQ-022 Reset SHALL set PC=0, AR=0, IR=0, R0-R3=0, flag=0, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, error=0.
REQ-023 Reset asserted during an outstanding request SHALL drop mem_req on the next edge and discard any concurrent ack; reset SHALL override everything, including HALT.

Configuration
REQ-024 Macro PARAM_CPU_CORE_LDI_EN SHALL control LDI:
- Defined: opcode 9 executes LDI per REQ-016.
- Undefined: opcode 9 is illegal and enters HALT with error=1; no LDI logic is synthesised.

Verification
REQ-025 With DW=8, AW=8 and zero-wait memory, the bench SHALL cover:
- Memory {0x59,0x07,0x5A,0x07,0x16,0xF0}, mem[7]=0x05 (RD R1; RD R2; ADD R2+=R1; HALT) -> R2=0x0A, flag=0, halted=1, error=0, PC=6.
- SUB R0-R0 (0x20) then BRZ 0x10 (0x80,0x10) -> flag=1 and PC=0x10; repeat with R0=1 in a nonzero register -> BRZ skips, PC advances by 2.
- Three wait cycles per ack on a WR of R3=0xAB to 0x40 -> mem_addr, mem_we and mem_wdata held stable; exactly one write, mem[0x40]=0xAB.
- Program reaching PC 0xFF with a NOP -> PC wraps to 0x00.
- Opcode 0xC0 -> halted=1, error=1, mem_req stays 0; opcode 0x93 with the macro undefined -> same result; with the macro defined, 0x93 followed by 0x3C gives R3=0x3C.
- Reset pulsed while a fetch awaits ack, with ack arriving in the reset cycle -> all outputs return to reset values; the next fetch starts from address 0.

Source files
------------

// File: rtl/param_cpu_core.sv
// rtl/param_cpu_core.sv - multicycle four-register CPU core with a req/ack memory port
// Define PARAM_CPU_CORE_LDI_EN to enable the LDI opcode (otherwise opcode 9 is illegal).
module param_cpu_core #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          halted,
  output logic          error,
  output logic [AW-1:0] dbg_pc
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_OPND, S_DATA, S_HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_RD   = 4'h5;
  localparam logic [3:0] OP_WR   = 4'h6;
  localparam logic [3:0] OP_BR   = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
`ifdef PARAM_CPU_CORE_LDI_EN
  localparam logic [3:0] OP_LDI  = 4'h9;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, ar_q, ar_d, addr_q, addr_d;
  logic [7:0]    ir_q, ir_d;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [DW-1:0] wdata_q, wdata_d, alu_res, rs_val, rd_val;
  logic          flag_q, flag_d, error_q, error_d, req_q, req_d, we_q, we_d;
  logic [3:0]    op;
  logic [1:0]    src, dst;
  logic          xfer, op_legal, is_alu, needs_opnd;

  assign op     = ir_q[7:4];
  assign src    = ir_q[3:2];
  assign dst    = ir_q[1:0];
  assign rs_val = regs_q[src];
  assign rd_val = regs_q[dst];
  // An ack only counts while a request is actually outstanding.
  assign xfer   = req_q & mem_ack;
  assign is_alu = (op >= OP_ADD) && (op <= OP_NOT);

  always_comb begin
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_RD, OP_WR, OP_BR, OP_BRZ, OP_HALT: op_legal = 1'b1;
`ifdef PARAM_CPU_CORE_LDI_EN
      OP_LDI: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    needs_opnd = (op == OP_RD) || (op == OP_WR) || (op == OP_BR) || ((op == OP_BRZ) && flag_q);
`ifdef PARAM_CPU_CORE_LDI_EN
    if (op == OP_LDI) needs_opnd = 1'b1;
`endif
  end

  always_comb begin
    case (op)
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_NOT:  alu_res = ~rs_val;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (xfer) state_d = S_DECODE;
      S_DECODE: begin
        if (!op_legal || (op == OP_HALT)) state_d = S_HALT;
        else if (needs_opnd)              state_d = S_OPND;
        else                              state_d = S_FETCH;
      end
      S_OPND:   if (xfer) state_d = ((op == OP_RD) || (op == OP_WR)) ? S_DATA : S_FETCH;
      S_DATA:   if (xfer) state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // FETCH spends one cycle raising its request; operand and data requests are
  // launched on the edge that enters OPND/DATA so they complete in one cycle.
  always_comb begin
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    flag_d  = flag_q;
    error_d = error_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (mem_ack) begin
          ir_d  = mem_rdata[7:0];
          pc_d  = pc_q + AW'(1);
          req_d = 1'b0;
        end
      end
      S_DECODE: begin
        if (is_alu) begin
          regs_d[dst] = alu_res;
          flag_d      = (alu_res == '0);
        end
        if (!op_legal) error_d = 1'b1;
        if (needs_opnd) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end else if (op == OP_BRZ) begin
          pc_d = pc_q + AW'(1);
        end
      end
      S_OPND: begin
        if (xfer) begin
          pc_d  = pc_q + AW'(1);
          req_d = 1'b0;
          case (op)
            OP_RD, OP_WR: begin
              ar_d    = AW'(mem_rdata);
              req_d   = 1'b1;
              we_d    = (op == OP_WR);
              addr_d  = AW'(mem_rdata);
              wdata_d = (op == OP_WR) ? rs_val : wdata_q;
            end
            OP_BR, OP_BRZ: pc_d = AW'(mem_rdata);
`ifdef PARAM_CPU_CORE_LDI_EN
            OP_LDI: regs_d[dst] = mem_rdata;
`endif
            default: ;
          endcase
        end
      end
      S_DATA: begin
        if (xfer) begin
          req_d = 1'b0;
          we_d  = 1'b0;
          if (op == OP_RD) regs_d[dst] = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      flag_q  <= 1'b0;
      error_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      flag_q  <= flag_d;
      error_q <= error_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = (state_q == S_HALT);
  assign error     = error_q;
  assign dbg_pc    = pc_q;
endmodule

// File: tb/tb_param_cpu_core.sv
// tb/tb_param_cpu_core.sv - randomized and directed bench for param_cpu_core
// Instruction-level reference model predicts every memory access, CPI and halt state.
module tb_param_cpu_core;
  localparam int DW = 8;
  localparam int AW = 8;
`ifdef PARAM_CPU_CORE_LDI_EN
  localparam bit LDI_EN = 1'b1;
`else
  localparam bit LDI_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, mem_ack, halted, error;
  logic [AW-1:0] mem_addr, dbg_pc;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  param_cpu_core #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted),
    .error(error), .dbg_pc(dbg_pc)
  );

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    bit         is_fetch;
    int         lat;
  } acc_t;

  int         n_vec = 0;
  int         n_err = 0;
  acc_t       exp_q[$];
  logic [7:0] img  [256];
  logic [7:0] dmem [256];
  bit         m_halted, m_error;
  logic [7:0] m_pc;
  int         write_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic acc_t mk(input logic [7:0] a, input logic w, input logic [7:0] d,
                              input bit f, input int lat);
    acc_t e;
    e.addr = a; e.we = w; e.wdata = d; e.is_fetch = f; e.lat = lat;
    return e;
  endfunction

  // Executes the program one instruction at a time and lists the accesses it must make.
  function automatic void model_run(input int max_ins);
    logic [7:0] m [256];
    logic [7:0] r [4];
    logic [7:0] pc, ins, a, res;
    logic [3:0] op;
    logic [1:0] s, d;
    logic       flag;
    int         lat;
    for (int i = 0; i < 256; i++) m[i] = img[i];
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    pc = 8'h00; flag = 1'b0; m_halted = 1'b0; m_error = 1'b0;
    exp_q.delete();
    for (int n = 0; n < max_ins && !m_halted; n++) begin
      ins = m[pc]; op = ins[7:4]; s = ins[3:2]; d = ins[1:0];
      case (op)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h4: lat = 3;
        4'h5, 4'h6: lat = 5;
        4'h7: lat = 4;
        4'h8: lat = flag ? 4 : 3;
        4'h9: lat = LDI_EN ? 4 : 0;
        default: lat = 0;
      endcase
      exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b1, lat));
      pc = pc + 8'd1;
      case (op)
        4'h0: ;
        4'h1, 4'h2, 4'h3, 4'h4: begin
          if (op == 4'h1)      res = r[d] + r[s];
          else if (op == 4'h2) res = r[d] - r[s];
          else if (op == 4'h3) res = r[d] & r[s];
          else                 res = ~r[s];
          r[d] = res; flag = (res == 8'h00);
        end
        4'h5, 4'h6: begin
          exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b0, 0));
          a = m[pc]; pc = pc + 8'd1;
          if (op == 4'h5) begin
            exp_q.push_back(mk(a, 1'b0, 8'h00, 1'b0, 0)); r[d] = m[a];
          end else begin
            exp_q.push_back(mk(a, 1'b1, r[s], 1'b0, 0)); m[a] = r[s];
          end
        end
        4'h7: begin exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b0, 0)); pc = m[pc]; end
        4'h8: begin
          if (flag) begin exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b0, 0)); pc = m[pc]; end
          else pc = pc + 8'd1;
        end
        4'h9: begin
          if (LDI_EN) begin
            exp_q.push_back(mk(pc, 1'b0, 8'h00, 1'b0, 0)); r[d] = m[pc]; pc = pc + 8'd1;
          end else begin m_halted = 1'b1; m_error = 1'b1; end
        end
        4'hF: m_halted = 1'b1;
        default: begin m_halted = 1'b1; m_error = 1'b1; end
      endcase
    end
    m_pc = pc;
  endfunction

  task automatic check_reset_outs(input string nm);
    check({nm, ".mem_req"}, mem_req, 0);
    check({nm, ".mem_we"}, mem_we, 0);
    check({nm, ".mem_addr"}, mem_addr, 0);
    check({nm, ".mem_wdata"}, mem_wdata, 0);
    check({nm, ".halted"}, halted, 0);
    check({nm, ".error"}, error, 0);
    check({nm, ".dbg_pc"}, dbg_pc, 0);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs({nm, ".rst"});
    reset = 1'b0;
  endtask

  // Serves the DUT from dmem, with min_w..max_w wait cycles per request, and checks
  // each completed access, handshake stability, CPI and the final halt state.
  task automatic run_prog(input string nm, input int min_w, input int max_w, input int max_ins);
    int idx, cyc, wleft, wacc, prev_fi, prev_fc;
    bit busy, done;
    logic [7:0] ra, rd;
    logic rw;
    model_run(max_ins);
    for (int i = 0; i < 256; i++) dmem[i] = img[i];
    write_cnt = 0;
    do_reset(nm);
    idx = 0; cyc = 0; wleft = 0; wacc = 0; prev_fi = -1; prev_fc = 0; busy = 0; done = 0;
    ra = '0; rd = '0; rw = 1'b0;
    while (!done) begin
      cyc++;
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (cyc > 3000) begin
        check({nm, ".timeout"}, cyc, 0);
        done = 1;
      end else if (halted) begin
        check({nm, ".halt_at_access"}, idx, exp_q.size());
        check({nm, ".halted"}, halted, m_halted);
        check({nm, ".error"}, error, m_error);
        check({nm, ".final_pc"}, dbg_pc, m_pc);
        for (int k = 0; k < 3; k++) begin
          mem_ack = 1'b1;
          @(negedge clk);
          check({nm, ".halt_req"}, {halted, mem_req}, 2'b10);
        end
        mem_ack = 1'b0;
        done = 1;
      end else if (idx == exp_q.size() && !m_halted) begin
        done = 1;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1; ra = mem_addr; rw = mem_we; rd = mem_wdata;
          wleft = $urandom_range(max_w, min_w);
        end else begin
          check({nm, ".hold"}, {mem_addr, mem_we, mem_wdata}, {ra, rw, rd});
        end
        if (wleft > 0) begin
          wleft--; wacc++;
        end else begin
          mem_ack = 1'b1; busy = 0;
          if (idx >= exp_q.size()) begin
            check({nm, ".extra_access"}, idx, exp_q.size());
            done = 1;
          end else begin
            check($sformatf("%s.addr[%0d]", nm, idx), ra, exp_q[idx].addr);
            check($sformatf("%s.we[%0d]", nm, idx), rw, exp_q[idx].we);
            if (exp_q[idx].we) check($sformatf("%s.wdata[%0d]", nm, idx), rd, exp_q[idx].wdata);
            if (exp_q[idx].is_fetch) begin
              if (prev_fi >= 0)
                check($sformatf("%s.cpi[%0d]", nm, idx), cyc - prev_fc, exp_q[prev_fi].lat + wacc);
              prev_fi = idx; prev_fc = cyc; wacc = 0;
            end
            mem_rdata = dmem[ra];
            if (rw) begin dmem[ra] = rd; write_cnt++; end
            idx++;
          end
        end
      end else begin
        if (busy) begin
          check({nm, ".req_dropped"}, mem_req, 1);
          busy = 0;
        end
        if ($urandom_range(3, 0) == 0) mem_ack = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic clear_img(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) img[i] = fill;
  endtask

  task automatic gen_img();
    logic [3:0] ops [11];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hF};
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(19, 0) == 0) img[i] = 8'($urandom);
      else img[i] = {ops[$urandom_range(10, 0)], 4'($urandom)};
    end
  endtask

  task automatic reset_mid_fetch();
    int k;
    clear_img(8'h00);
    for (int i = 0; i < 256; i++) dmem[i] = img[i];
    do_reset("rstfetch");
    k = 0;
    while (!(mem_req && mem_addr == 8'h03) && k < 100) begin
      mem_ack = mem_req;
      mem_rdata = dmem[mem_addr];
      @(negedge clk);
      k++;
    end
    check("rstfetch.reach", k < 100, 1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hF0;
    @(negedge clk);
    check_reset_outs("rstfetch.during");
    mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    while (!mem_req && k < 5) begin @(negedge clk); k++; end
    check("rstfetch.next_req", mem_req, 1);
    check("rstfetch.next_addr", {mem_addr, mem_we}, 9'h000);
  endtask

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;

    clear_img(8'hF0);
    img[0] = 8'h59; img[1] = 8'h07; img[2] = 8'h5A; img[3] = 8'h07; img[4] = 8'h16;
    img[5] = 8'h00; img[6] = 8'hF0; img[7] = 8'h05;
    img[5] = 8'hF0;
    run_prog("rdadd", 0, 0, 50);
    check("rdadd.model_pc", m_pc, 8'h06);
    check("rdadd.pc", dbg_pc, 8'h06);
    check("rdadd.err", {halted, error}, 2'b10);

    clear_img(8'hF0);
    img[0] = 8'h59; img[1] = 8'h07; img[2] = 8'h5A; img[3] = 8'h07; img[4] = 8'h16;
    img[5] = 8'h68; img[6] = 8'h40; img[7] = 8'h05; img[8] = 8'h80; img[9] = 8'h30;
    img[7] = 8'h05;
    img[5] = 8'h68; img[6] = 8'h40;
    img[8] = 8'h80; img[9] = 8'h30; img[10] = 8'hF0;
    clear_img(8'hF0);
    img[0] = 8'h59; img[1] = 8'h20; img[2] = 8'h5A; img[3] = 8'h20; img[4] = 8'h16;
    img[5] = 8'h68; img[6] = 8'h40; img[7] = 8'h80; img[8] = 8'h30; img[9] = 8'hF0;
    img[8'h20] = 8'h05;
    run_prog("rdaddwr", 0, 0, 50);
    check("rdaddwr.r2", dmem[8'h40], 8'h0A);
    check("rdaddwr.flag0_pc", dbg_pc, 8'h0A);

    clear_img(8'hF0);
    img[0] = 8'h20; img[1] = 8'h80; img[2] = 8'h10;
    run_prog("brz_taken", 0, 0, 50);
    check("brz_taken.model_pc", m_pc, 8'h11);
    check("brz_taken.pc", dbg_pc, 8'h11);

    clear_img(8'hF0);
    img[0] = 8'h51; img[1] = 8'h20; img[2] = 8'h21; img[3] = 8'h80; img[4] = 8'h10;
    img[8'h20] = 8'h01;
    run_prog("brz_skip", 0, 0, 50);
    check("brz_skip.pc", dbg_pc, 8'h06);

    clear_img(8'hF0);
    img[0] = 8'h53; img[1] = 8'h30; img[2] = 8'h6C; img[3] = 8'h40; img[8'h30] = 8'hAB;
    run_prog("wait3", 3, 3, 50);
    check("wait3.mem40", dmem[8'h40], 8'hAB);
    check("wait3.writes", write_cnt, 1);

    clear_img(8'hF0);
    img[0] = 8'h70; img[1] = 8'hFF; img[8'hFF] = 8'h00;
    run_prog("pcwrap", 0, 1, 3);
    check("pcwrap.model_addr", exp_q[3].addr, 8'h00);

    clear_img(8'hF0);
    img[0] = 8'hC0;
    run_prog("illegal", 0, 0, 10);
    check("illegal.state", {halted, error, mem_req}, 3'b110);
    check("illegal.pc", dbg_pc, 8'h01);

    clear_img(8'hF0);
    img[0] = 8'h93; img[1] = 8'h3C; img[2] = 8'h6C; img[3] = 8'h50;
    run_prog("ldi", 0, 2, 10);
`ifdef PARAM_CPU_CORE_LDI_EN
    check("ldi.r3", dmem[8'h50], 8'h3C);
    check("ldi.state", {halted, error}, 2'b10);
`else
    check("ldi.state", {halted, error, mem_req}, 3'b110);
    check("ldi.pc", dbg_pc, 8'h01);
`endif

    reset_mid_fetch();

    for (int t = 0; t < 25; t++) begin
      gen_img();
      run_prog($sformatf("rand%0d", t), 0, (t % 3 == 0) ? 0 : 3, 60);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
